// File: rtl/gs_project_engine_pkg.sv
// Shared definitions for the Gram-Schmidt projection engine.
// Holds the controller state encoding, default configuration values,
// the widths derived from them, and the saturating clamp used by the datapath.
// No ports: this file is a package.
package qr_pkg;

   localparam int GS_DATA_WIDTH = 16;
   localparam int GS_FRAC_BITS  = 8;
   localparam int GS_N          = 3;
   localparam int GS_MAX_Q      = 3;

   // Widths for the default configuration; modules recompute these from their own parameters
   localparam int ACC_W  = 2 * GS_DATA_WIDTH + $clog2(GS_N);
   localparam int IDX_W  = (GS_MAX_Q > 1) ? $clog2(GS_MAX_Q) : 1;
   localparam int QCNT_W = $clog2(GS_MAX_Q + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_V,
      DOT,
      R_EMIT,
      UPDATE,
      OUT
   } state_t;

   // Clamp a wide signed value into a signed word of 'width' bits
   function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (x > hi) return hi;
      else if (x < lo) return lo;
      else return x;
   endfunction

endpackage

// File: rtl/gs_project_engine_if.sv
// Handshake bundle of the projection engine.
// slave  : seen by the engine (q/v inputs, u_out_ready in; r/u streams and status out)
// master : seen by whoever feeds the engine and drains its results
interface gs_project_engine_if #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_Q      = 3
);
   localparam int IDX_LEN = (MAX_Q > 1) ? $clog2(MAX_Q) : 1;
   localparam int CNT_LEN = $clog2(MAX_Q + 1);

   logic                  q_clear;
   logic                  q_in_valid;
   logic                  q_in_ready;
   logic [DATA_WIDTH-1:0] q_in_data;
   logic [CNT_LEN-1:0]    q_count;
   logic                  v_in_valid;
   logic                  v_in_ready;
   logic [DATA_WIDTH-1:0] v_in_data;
   logic                  r_out_valid;
   logic [IDX_LEN-1:0]    r_out_idx;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  u_out_valid;
   logic                  u_out_ready;
   logic [DATA_WIDTH-1:0] u_out_data;
   logic                  u_out_last;
   logic                  busy;
   logic                  overflow;

   modport master (
      output q_clear, q_in_valid, q_in_data, v_in_valid, v_in_data, u_out_ready,
      input  q_in_ready, q_count, v_in_ready, r_out_valid, r_out_idx, r_out_data,
             u_out_valid, u_out_data, u_out_last, busy, overflow
   );

   modport slave (
      input  q_clear, q_in_valid, q_in_data, v_in_valid, v_in_data, u_out_ready,
      output q_in_ready, q_count, v_in_ready, r_out_valid, r_out_idx, r_out_data,
             u_out_valid, u_out_data, u_out_last, busy, overflow
   );

endinterface

// File: rtl/gs_project_engine_mac_sat.sv
// Shared arithmetic unit of the projection engine: one signed multiplier feeding
// either an accumulate path (dot product, result scaled and saturated) or a
// scale-and-subtract path (residual update, saturated).
// Ports: sub_mode selects the subtract path; op_a/op_b multiplier operands;
// acc_in/acc_out running accumulator; sub_in minuend; sat_out saturated word;
// clamp high when sat_out had to be clamped.
module gs_mac_sat
   import qr_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_W      = 34
)(
   input  logic                         sub_mode,
   input  logic signed [DATA_WIDTH-1:0] op_a,
   input  logic signed [DATA_WIDTH-1:0] op_b,
   input  logic signed [DATA_WIDTH-1:0] sub_in,
   input  logic signed [ACC_W-1:0]      acc_in,
   output logic signed [ACC_W-1:0]      acc_out,
   output logic signed [DATA_WIDTH-1:0] sat_out,
   output logic                         clamp
);
   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0] product;
   logic signed [63:0]   wide;
   logic signed [63:0]   limited;

   // Full-precision product; the accumulate path also yields the scaled r value
   // so the last MAC cycle can register r directly.
   always_comb begin
      product = PW'(op_a) * PW'(op_b);
      acc_out = acc_in + ACC_W'(product);
      if (sub_mode) wide = 64'(sub_in) - 64'(product >>> FRAC_BITS);
      else          wide = 64'(acc_out >>> FRAC_BITS);
      limited = sat(wide, DATA_WIDTH);
      sat_out = limited[DATA_WIDTH-1:0];
      clamp   = (limited != wide);
   end

endmodule

// File: rtl/gs_project_engine.sv
// Gram-Schmidt projection engine. Stores up to MAX_Q q vectors of length N,
// takes a column v, emits r_j = q_j . u for each stored q (modified Gram-Schmidt,
// u updated after every projection) and streams out the residual u.
// Ports: clk, reset (synchronous, active high); bus carries the q load stream,
// q_clear, the v stream, the r pulse stream, the u residual stream, q_count,
// busy and the sticky overflow flag.
module gs_project_engine
   import qr_pkg::*;
#(
   parameter int DATA_WIDTH = GS_DATA_WIDTH,
   parameter int FRAC_BITS  = GS_FRAC_BITS,
   parameter int N          = GS_N,
   parameter int MAX_Q      = GS_MAX_Q
)(
   input logic                clk,
   input logic                reset,
   gs_project_engine_if.slave bus
);
   localparam int ACC_LEN = 2 * DATA_WIDTH + $clog2(N);
   localparam int IDX_LEN = (MAX_Q > 1) ? $clog2(MAX_Q) : 1;
   localparam int CNT_LEN = $clog2(MAX_Q + 1);
   localparam int EW      = $clog2(N);

   state_t                      state;
   logic [CNT_LEN-1:0]          q_count;
   logic [EW-1:0]               q_e;
   logic [EW-1:0]               e;
   logic [EW-1:0]               o;
   logic [IDX_LEN-1:0]          j;
   logic signed [ACC_LEN-1:0]   acc;
   logic                        r_out_valid;
   logic [IDX_LEN-1:0]          r_out_idx;
   logic signed [DATA_WIDTH-1:0] r_out_data;
   logic                        u_out_valid;
   logic [DATA_WIDTH-1:0]       u_out_data;
   logic                        u_out_last;
   logic                        overflow;

   logic signed [DATA_WIDTH-1:0] q_mem [MAX_Q][N];
   logic signed [DATA_WIDTH-1:0] u_mem [N];

   logic signed [DATA_WIDTH-1:0] op_a;
   logic signed [DATA_WIDTH-1:0] op_b;
   logic signed [DATA_WIDTH-1:0] sub_in;
   logic signed [ACC_LEN-1:0]    acc_out;
   logic signed [DATA_WIDTH-1:0] sat_out;
   logic                         clamp;

   // Readies are held low while reset is asserted so nothing is accepted then
   assign bus.q_in_ready  = !reset && (state == IDLE) && (q_count < CNT_LEN'(MAX_Q));
   assign bus.v_in_ready  = !reset && ((state == IDLE) || (state == LOAD_V));
   assign bus.busy        = (state != IDLE);
   assign bus.q_count     = q_count;
   assign bus.r_out_valid = r_out_valid;
   assign bus.r_out_idx   = r_out_idx;
   assign bus.r_out_data  = r_out_data;
   assign bus.u_out_valid = u_out_valid;
   assign bus.u_out_data  = u_out_data;
   assign bus.u_out_last  = u_out_last;
   assign bus.overflow    = overflow;

   // The single multiplier computes q_j[e]*u[e] in DOT and r_j*q_j[e] in UPDATE
   always_comb begin
      op_a   = q_mem[j][e];
      op_b   = u_mem[e];
      sub_in = u_mem[e];
      if (state == UPDATE) begin
         op_a = r_out_data;
         op_b = q_mem[j][e];
      end
   end

   gs_mac_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_W      (ACC_LEN)
   ) u_mac (
      .sub_mode (state == UPDATE),
      .op_a     (op_a),
      .op_b     (op_b),
      .sub_in   (sub_in),
      .acc_in   (acc),
      .acc_out  (acc_out),
      .sat_out  (sat_out),
      .clamp    (clamp)
   );

   // Controller: loads q/v, runs N-cycle dot and update phases per stored q,
   // then streams u. r_out_data doubles as the r operand during UPDATE.
   // u_mem[0] is never written in the cycle OUT is entered (N>=2), so it can be
   // preloaded into u_out_data on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         q_count     <= '0;
         q_e         <= '0;
         e           <= '0;
         o           <= '0;
         j           <= '0;
         acc         <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_data  <= '0;
         u_out_valid <= 1'b0;
         u_out_data  <= '0;
         u_out_last  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.q_clear) begin
                  q_count  <= '0;
                  q_e      <= '0;
                  overflow <= 1'b0;
               end else if (bus.q_in_valid && (q_count < CNT_LEN'(MAX_Q))) begin
                  q_mem[q_count][q_e] <= bus.q_in_data;
                  if (q_e == EW'(N - 1)) begin
                     q_e     <= '0;
                     q_count <= q_count + 1'b1;
                  end else begin
                     q_e <= q_e + 1'b1;
                  end
               end
               if (bus.v_in_valid) begin
                  u_mem[0] <= bus.v_in_data;
                  e        <= EW'(1);
                  state    <= LOAD_V;
               end
            end
            LOAD_V: begin
               if (bus.v_in_valid) begin
                  u_mem[e] <= bus.v_in_data;
                  if (e == EW'(N - 1)) begin
                     e <= '0;
                     j <= '0;
                     if (q_count != '0) begin
                        state <= DOT;
                     end else begin
                        state       <= OUT;
                        o           <= '0;
                        u_out_valid <= 1'b1;
                        u_out_data  <= u_mem[0];
                        u_out_last  <= 1'b0;
                     end
                  end else begin
                     e <= e + 1'b1;
                  end
               end
            end
            DOT: begin
               acc <= acc_out;
               if (e == EW'(N - 1)) begin
                  e           <= '0;
                  r_out_data  <= sat_out;
                  r_out_idx   <= j;
                  r_out_valid <= 1'b1;
                  if (clamp) overflow <= 1'b1;
                  state       <= R_EMIT;
               end else begin
                  e <= e + 1'b1;
               end
            end
            R_EMIT: begin
               r_out_valid <= 1'b0;
               acc         <= '0;
               state       <= UPDATE;
            end
            UPDATE: begin
               u_mem[e] <= sat_out;
               if (clamp) overflow <= 1'b1;
               if (e == EW'(N - 1)) begin
                  e <= '0;
                  if ((32'(j) + 32'd1) < 32'(q_count)) begin
                     j     <= j + 1'b1;
                     state <= DOT;
                  end else begin
                     j           <= '0;
                     state       <= OUT;
                     o           <= '0;
                     u_out_valid <= 1'b1;
                     u_out_data  <= u_mem[0];
                     u_out_last  <= 1'b0;
                  end
               end else begin
                  e <= e + 1'b1;
               end
            end
            OUT: begin
               if (bus.u_out_ready) begin
                  if (o == EW'(N - 1)) begin
                     o           <= '0;
                     u_out_valid <= 1'b0;
                     u_out_data  <= '0;
                     u_out_last  <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     o          <= o + 1'b1;
                     u_out_data <= u_mem[o + 1'b1];
                     u_out_last <= ((o + 1'b1) == EW'(N - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gs_project_engine.sv
// Self-checking bench for gs_project_engine: hand-derived vector table,
// stall / reset corner sequences and randomized columns against a
// behavioural model of modified Gram-Schmidt in plain integer arithmetic.
`timescale 1ns/1ps
module tb_gs_project_engine;
   import qr_pkg::*;

   localparam int DW = GS_DATA_WIDTH;
   localparam int FB = GS_FRAC_BITS;
   localparam int NN = GS_N;
   localparam int MQ = GS_MAX_Q;
   localparam int BUDGET = 300;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gs_project_engine_if #(.DATA_WIDTH(DW), .MAX_Q(MQ)) bus ();

   gs_project_engine #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FB),
      .N          (NN),
      .MAX_Q      (MQ)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Column under test: bank contents, v, and the expected results
   int  mk;
   int  mq [MQ][NN];
   int  mv [NN];
   int  mr [MQ];
   int  mu [NN];
   bit  movf;

   typedef struct packed {
      int                            k;
      logic [MQ-1:0][NN-1:0][DW-1:0] q;
      logic [NN-1:0][DW-1:0]         v;
      logic [MQ-1:0][DW-1:0]         r;
      logic [NN-1:0][DW-1:0]         u;
      logic                          ovf;
   } vec_t;

   vec_t tbl [4];

   function automatic logic [DW-1:0] w(input int x);
      return x[DW-1:0];
   endfunction

   task automatic check_output(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic longint sat_ref(input longint x);
      longint hi;
      longint lo;
      hi = (64'sd1 <<< (DW - 1)) - 1;
      lo = -(64'sd1 <<< (DW - 1));
      if (x > hi) begin movf = 1'b1; return hi; end
      if (x < lo) begin movf = 1'b1; return lo; end
      return x;
   endfunction

   // Modified Gram-Schmidt on integers: r_j = floor(q_j.u / 2^FB), u -= floor(r_j*q_j / 2^FB)
   task automatic compute_model();
      longint u [NN];
      longint acc;
      longint r;
      movf = 1'b0;
      for (int i = 0; i < NN; i++) u[i] = mv[i];
      for (int jj = 0; jj < mk; jj++) begin
         acc = 0;
         for (int i = 0; i < NN; i++) acc += longint'(mq[jj][i]) * u[i];
         r = sat_ref(acc >>> FB);
         mr[jj] = int'(r);
         for (int i = 0; i < NN; i++) u[i] = sat_ref(u[i] - ((r * mq[jj][i]) >>> FB));
      end
      for (int i = 0; i < NN; i++) mu[i] = int'(u[i]);
   endtask

   task automatic wait_q_ready();
      int t = 0;
      while (!bus.q_in_ready && t < 50) begin @(negedge clk); t++; end
      check_output("q_in_ready wait", bus.q_in_ready, 1);
   endtask

   task automatic wait_v_ready();
      int t = 0;
      while (!bus.v_in_ready && t < 50) begin @(negedge clk); t++; end
      check_output("v_in_ready wait", bus.v_in_ready, 1);
   endtask

   // Clears the bank (colliding with a dropped q element after a partial one), then loads mk vectors
   task automatic load_bank();
      bus.q_in_valid = 1'b1;
      bus.q_in_data  = w(4660);
      @(negedge clk);
      bus.q_clear    = 1'b1;
      bus.q_in_data  = w(30583);
      @(negedge clk);
      bus.q_clear    = 1'b0;
      bus.q_in_valid = 1'b0;
      check_output("q_count after clear", bus.q_count, 0);
      check_output("overflow after clear", bus.overflow, 0);
      for (int jj = 0; jj < mk; jj++) begin
         for (int i = 0; i < NN; i++) begin
            bus.q_in_valid = 1'b1;
            bus.q_in_data  = w(mq[jj][i]);
            wait_q_ready();
            @(negedge clk);
         end
      end
      bus.q_in_valid = 1'b0;
      check_output("q_count loaded", bus.q_count, mk);
   endtask

   task automatic send_v();
      for (int i = 0; i < NN; i++) begin
         bus.v_in_valid = 1'b1;
         bus.v_in_data  = w(mv[i]);
         wait_v_ready();
         @(negedge clk);
      end
      bus.v_in_valid = 1'b0;
   endtask

   // Watches r pulses and the u stream from the cycle after the last v handshake.
   // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
   task automatic run_column(input int mode);
      int       cyc;
      int       r_seen;
      int       u_seen;
      int       p;
      bit       done;
      bit       first_u;
      bit       prev_stall;
      bit       rdy;
      longint   prev_data;
      longint   prev_last;
      longint   ud;
      cyc = 1; r_seen = 0; u_seen = 0; p = 0;
      done = 1'b0; first_u = 1'b1; prev_stall = 1'b0;
      prev_data = 0; prev_last = 0;
      while (!done && cyc < BUDGET) begin
         if (bus.r_out_valid) begin
            if (r_seen < mk) begin
               check_output("r_out_idx", bus.r_out_idx, r_seen);
               check_output("r_out_data", longint'($signed(bus.r_out_data)), mr[r_seen]);
               check_output("r pulse cycle", cyc, 1 + r_seen * (2 * NN + 1) + NN);
            end else begin
               check_output("r pulse count", r_seen + 1, mk);
            end
            r_seen++;
         end
         bus.u_out_ready = 1'b0;
         if (bus.u_out_valid) begin
            ud = longint'($signed(bus.u_out_data));
            if (first_u) check_output("first u cycle", cyc, mk * (2 * NN + 1) + 1);
            first_u = 1'b0;
            if (prev_stall) begin
               check_output("u_out_data held", ud, prev_data);
               check_output("u_out_last held", bus.u_out_last, prev_last);
            end
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = ((p % 3) == 0);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            p++;
            bus.u_out_ready = rdy;
            if (rdy) begin
               if (u_seen < NN) begin
                  check_output("u_out_data", ud, mu[u_seen]);
                  check_output("u_out_last", bus.u_out_last, (u_seen == NN - 1) ? 1 : 0);
               end
               u_seen++;
               if (u_seen == NN) done = 1'b1;
            end
            prev_stall = !rdy;
            prev_data  = ud;
            prev_last  = bus.u_out_last;
         end else begin
            prev_stall = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      bus.u_out_ready = 1'b0;
      check_output("r pulses total", r_seen, mk);
      check_output("u elements total", u_seen, NN);
      check_output("busy after column", bus.busy, 0);
      check_output("overflow after column", bus.overflow, movf);
      check_output("q_count retained", bus.q_count, mk);
   endtask

   task automatic apply_stimulus(input int mode);
      load_bank();
      send_v();
      run_column(mode);
   endtask

   task automatic load_from_table(input int t);
      mk   = tbl[t].k;
      movf = tbl[t].ovf;
      for (int jj = 0; jj < MQ; jj++) begin
         mr[jj] = int'($signed(tbl[t].r[jj]));
         for (int i = 0; i < NN; i++) mq[jj][i] = int'($signed(tbl[t].q[jj][i]));
      end
      for (int i = 0; i < NN; i++) begin
         mv[i] = int'($signed(tbl[t].v[i]));
         mu[i] = int'($signed(tbl[t].u[i]));
      end
   endtask

   task automatic set_unit_column();
      mk = 1;
      mq[0][0] = 256; mq[0][1] = 0; mq[0][2] = 0;
      mv[0] = 768; mv[1] = 1024; mv[2] = 0;
      mr[0] = 768;
      mu[0] = 0; mu[1] = 1024; mu[2] = 0;
      movf = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Hand-derived vectors, 1.0 = 256
      for (int t = 0; t < 4; t++) tbl[t] = '0;
      tbl[0].k = 1;
      tbl[0].q[0][0] = w(256);
      tbl[0].v[0] = w(768); tbl[0].v[1] = w(1024);
      tbl[0].r[0] = w(768);
      tbl[0].u[1] = w(1024);
      tbl[1].k = 2;
      tbl[1].q[0][0] = w(256); tbl[1].q[1][1] = w(256);
      tbl[1].v[0] = w(768); tbl[1].v[1] = w(1024);
      tbl[1].r[0] = w(768); tbl[1].r[1] = w(1024);
      tbl[2].k = 0;
      tbl[2].v[0] = w(5); tbl[2].v[1] = w(-7); tbl[2].v[2] = w(9);
      tbl[2].u[0] = w(5); tbl[2].u[1] = w(-7); tbl[2].u[2] = w(9);
      tbl[3].k = 1;
      for (int i = 0; i < NN; i++) begin
         tbl[3].q[0][i] = w(256);
         tbl[3].v[i]    = w(32767);
      end
      tbl[3].r[0] = w(32767);
      tbl[3].ovf  = 1'b1;

      reset           = 1'b1;
      bus.q_clear     = 1'b0;
      bus.q_in_valid  = 1'b0;
      bus.q_in_data   = '0;
      bus.v_in_valid  = 1'b0;
      bus.v_in_data   = '0;
      bus.u_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_output("q_in_ready in reset", bus.q_in_ready, 0);
      check_output("v_in_ready in reset", bus.v_in_ready, 0);
      check_output("busy in reset", bus.busy, 0);
      reset = 1'b0;
      #1;
      check_output("q_in_ready idle", bus.q_in_ready, 1);
      check_output("v_in_ready idle", bus.v_in_ready, 1);
      check_output("q_count idle", bus.q_count, 0);
      check_output("r_out_valid idle", bus.r_out_valid, 0);
      check_output("u_out_valid idle", bus.u_out_valid, 0);
      check_output("u_out_last idle", bus.u_out_last, 0);
      check_output("overflow idle", bus.overflow, 0);
      check_output("busy idle", bus.busy, 0);
      @(negedge clk);

      $display("[TB] table vectors");
      for (int t = 0; t < 4; t++) begin
         load_from_table(t);
         apply_stimulus(0);
      end

      $display("[TB] stalled output stream");
      set_unit_column();
      apply_stimulus(1);

      $display("[TB] reset during DOT");
      set_unit_column();
      load_bank();
      send_v();
      @(negedge clk);
      check_output("busy in DOT", bus.busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_output("q_in_ready while reset", bus.q_in_ready, 0);
      reset = 1'b0;
      #1;
      check_output("busy after reset", bus.busy, 0);
      check_output("q_count after reset", bus.q_count, 0);
      check_output("r_out_valid after reset", bus.r_out_valid, 0);
      check_output("u_out_valid after reset", bus.u_out_valid, 0);
      check_output("q_in_ready after reset", bus.q_in_ready, 1);
      @(negedge clk);
      apply_stimulus(0);

      $display("[TB] randomized columns");
      for (int it = 0; it < 24; it++) begin
         bit big;
         big = ($urandom_range(0, 3) == 0);
         mk  = int'($urandom_range(0, MQ));
         for (int jj = 0; jj < MQ; jj++)
            for (int i = 0; i < NN; i++)
               mq[jj][i] = big ? int'($urandom_range(0, 65535)) - 32768
                               : int'($urandom_range(0, 600)) - 300;
         for (int i = 0; i < NN; i++)
            mv[i] = big ? int'($urandom_range(0, 65535)) - 32768
                        : int'($urandom_range(0, 4000)) - 2000;
         compute_model();
         apply_stimulus(2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
